// File: rtl/ddr_burst_chip.sv
// -----------------------------------------------------------------------------
// ddr_burst_chip
//
// Storage and timing endpoint of a DRAM chip. It accepts one RD/WR command at
// a time and plays it out as a BL8 or BC4 burst. Column order within a burst is
// sequential and wraps inside the burst-aligned window. Write beats are sampled
// CWL cycles after the accept edge. Read beats are driven CL cycles after it.
//
// Ports
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   cmd_valid    command request
//   cmd_ready    idle and able to accept a command (registered)
//   cmd_we       1 = write, 0 = read
//   cmd_bc4      1 = 4-beat burst chop, 0 = BL8
//   cmd_bg       bank group
//   cmd_ba       bank within group
//   cmd_row      row address
//   cmd_col      starting column
//   dqin         write data beat
//   wr_beat      high in each cycle where dqin is sampled (registered)
//   dqout        read data beat, 0 outside read beats (registered)
//   dqout_valid  read beat valid (registered)
// -----------------------------------------------------------------------------
module ddr_burst_chip #(
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int ADDRWIDTH    = 4,
    parameter int COLWIDTH     = 5,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8,
    parameter int CL           = 4,
    parameter int CWL          = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic                    cmd_bc4,
    input  logic [BGWIDTH-1:0]      cmd_bg,
    input  logic [BAWIDTH-1:0]      cmd_ba,
    input  logic [ADDRWIDTH-1:0]    cmd_row,
    input  logic [COLWIDTH-1:0]     cmd_col,
    input  logic [DEVICE_WIDTH-1:0] dqin,
    output logic                    wr_beat,
    output logic [DEVICE_WIDTH-1:0] dqout,
    output logic                    dqout_valid
);

    // {bank group, bank, row} is kept as one field; the column is appended
    // per beat to form the flat storage index.
    localparam int BRW     = BGWIDTH + BAWIDTH + ADDRWIDTH;
    localparam int MEMW    = BRW + COLWIDTH;
    localparam int DEPTH   = 1 << MEMW;
    localparam int LAT_MAX = (CL > CWL) ? CL : CWL;
    localparam int CNTW    = $clog2(LAT_MAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;

    logic [1:0]              r_state;
    logic [CNTW-1:0]         r_cnt;
    logic [2:0]              r_beat;
    logic                    r_we;
    logic                    r_bc4;
    logic [BRW-1:0]          r_bank;
    logic [COLWIDTH-1:0]     r_col;
    logic                    r_ready;
    logic                    r_wr_beat;
    logic                    r_dqout_valid;
    logic [DEVICE_WIDTH-1:0] r_dqout;

    logic [DEVICE_WIDTH-1:0] r_mem [DEPTH];

    logic [1:0]              w_state_nx;
    logic [CNTW-1:0]         w_cnt_nx;
    logic [2:0]              w_beat_nx;
    logic                    w_we_nx;
    logic                    w_bc4_nx;
    logic [BRW-1:0]          w_bank_nx;
    logic [COLWIDTH-1:0]     w_col_nx;
    logic                    w_accept;
    logic                    w_last;
    logic [CNTW-1:0]         w_lat_m1;
    logic                    w_rd_nx;
    logic                    w_wr_nx;
    logic [MEMW-1:0]         w_addr_cur;
    logic [MEMW-1:0]         w_addr_nx;

    // Wrapped column for a beat: only the low 3 (BL8) or 2 (BC4) bits advance,
    // with no carry into the upper column bits.
    function automatic logic [COLWIDTH-1:0] beat_col(
        input logic [COLWIDTH-1:0] col,
        input logic                bc4,
        input logic [2:0]          beat
    );
        logic [COLWIDTH-1:0] c;
        c = col;
        if (bc4) c[1:0] = col[1:0] + beat[1:0];
        else     c[2:0] = col[2:0] + beat;
        return c;
    endfunction

    assign w_accept = cmd_valid && r_ready;
    assign w_last   = (r_beat == (r_bc4 ? 3'(BL / 2 - 1) : 3'(BL - 1)));
    assign w_lat_m1 = cmd_we ? CNTW'(CWL - 1) : CNTW'(CL - 1);

    // Next-state logic. The WAIT counter leaves at 1 rather than 0 so that,
    // with registered outputs, the first beat lands exactly L cycles after the
    // accept edge; a latency of 1 skips WAIT entirely.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_beat_nx  = r_beat;
        w_we_nx    = r_we;
        w_bc4_nx   = r_bc4;
        w_bank_nx  = r_bank;
        w_col_nx   = r_col;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_we_nx   = cmd_we;
                    w_bc4_nx  = cmd_bc4;
                    w_bank_nx = {cmd_bg, cmd_ba, cmd_row};
                    w_col_nx  = cmd_col;
                    w_beat_nx = 3'd0;
                    w_cnt_nx  = w_lat_m1;
                    w_state_nx = (w_lat_m1 == '0) ? S_BURST : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == CNTW'(1)) begin
                    w_state_nx = S_BURST;
                    w_beat_nx  = 3'd0;
                end
                w_cnt_nx = r_cnt - CNTW'(1);
            end
            S_BURST: begin
                if (w_last) w_state_nx = S_IDLE;
                else        w_beat_nx  = r_beat + 3'd1;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign w_rd_nx    = (w_state_nx == S_BURST) && !w_we_nx;
    assign w_wr_nx    = (w_state_nx == S_BURST) &&  w_we_nx;
    assign w_addr_cur = {r_bank, beat_col(r_col, r_bc4, r_beat)};
    assign w_addr_nx  = {w_bank_nx, beat_col(w_col_nx, w_bc4_nx, w_beat_nx)};

    // Control state and registered outputs. Outputs are computed from the
    // next state so they line up with the cycle the FSM is in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_beat        <= 3'd0;
            r_we          <= 1'b0;
            r_bc4         <= 1'b0;
            r_bank        <= '0;
            r_col         <= '0;
            r_ready       <= 1'b0;
            r_wr_beat     <= 1'b0;
            r_dqout_valid <= 1'b0;
            r_dqout       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_beat        <= w_beat_nx;
            r_we          <= w_we_nx;
            r_bc4         <= w_bc4_nx;
            r_bank        <= w_bank_nx;
            r_col         <= w_col_nx;
            r_ready       <= (w_state_nx == S_IDLE);
            r_wr_beat     <= w_wr_nx;
            r_dqout_valid <= w_rd_nx;
            r_dqout       <= w_rd_nx ? r_mem[w_addr_nx] : '0;
        end
    end

    // NOTE: the storage array has no reset; its contents survive reset_n and
    // unwritten words stay unknown. Reset stops further writes by forcing the
    // FSM out of BURST.
    always_ff @(posedge clk) begin
        if (r_state == S_BURST && r_we)
            r_mem[w_addr_cur] <= dqin;
    end

    assign cmd_ready   = r_ready;
    assign wr_beat     = r_wr_beat;
    assign dqout       = r_dqout;
    assign dqout_valid = r_dqout_valid;

endmodule

// File: tb/tb_ddr_burst_chip.sv
// -----------------------------------------------------------------------------
// tb_ddr_burst_chip
//
// Directed bench for ddr_burst_chip using default parameters (CL=4, CWL=3, x4).
// Inputs change on the falling edge and outputs are sampled there too, so each
// sample sits half a cycle away from the active rising edge. Burst data is
// packed four bits per beat, beat 0 in the low nibble.
// -----------------------------------------------------------------------------
module tb_ddr_burst_chip;

    localparam int CL  = 4;
    localparam int CWL = 3;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_we    = 1'b0;
    logic       cmd_bc4   = 1'b0;
    logic [1:0] cmd_bg    = '0;
    logic [1:0] cmd_ba    = '0;
    logic [3:0] cmd_row   = '0;
    logic [4:0] cmd_col   = '0;
    logic [3:0] dqin      = '0;
    logic       cmd_ready;
    logic       wr_beat;
    logic [3:0] dqout;
    logic       dqout_valid;

    int n_checks = 0;
    int n_fail   = 0;

    ddr_burst_chip dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_bc4     (cmd_bc4),
        .cmd_bg      (cmd_bg),
        .cmd_ba      (cmd_ba),
        .cmd_row     (cmd_row),
        .cmd_col     (cmd_col),
        .dqin        (dqin),
        .wr_beat     (wr_beat),
        .dqout       (dqout),
        .dqout_valid (dqout_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents a command and waits (bounded) for it to be accepted. Returns one
    // time unit after the accept edge, i.e. early in cycle T+1. cmd_valid is
    // left high; the caller drops it or keeps it for a queued command.
    task automatic start_cmd(input logic we, input logic bc4, input logic [1:0] bg,
                             input logic [1:0] ba, input logic [3:0] row,
                             input logic [4:0] col, output int waited);
        cmd_we    = we;
        cmd_bc4   = bc4;
        cmd_bg    = bg;
        cmd_ba    = ba;
        cmd_row   = row;
        cmd_col   = col;
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) check("accept_timeout", {7'd0, cmd_ready}, 8'd1);
        @(posedge clk);
        #1;
    endtask

    // Walks cycles T+1 .. T+CWL+blen of a write, driving dqin for each beat and
    // checking wr_beat and cmd_ready. A nonzero abort_k asserts reset in the
    // middle of cycle T+abort_k, after that cycle's beat has been presented.
    task automatic run_write(input string name, input logic [31:0] data,
                             input int blen, input int abort_k);
        for (int k = 1; k <= CWL + blen; k++) begin
            logic beat_on;
            @(negedge clk);
            beat_on = (k >= CWL) && (k < CWL + blen);
            check($sformatf("%s wr_beat k=%0d", name, k), {7'd0, wr_beat}, {7'd0, beat_on});
            check($sformatf("%s ready k=%0d", name, k), {7'd0, cmd_ready},
                  {7'd0, (k == CWL + blen)});
            dqin = beat_on ? data[4 * (k - CWL) +: 4] : 4'h0;
            if (k == abort_k) begin
                reset_n = 1'b0;
                return;
            end
        end
        dqin = 4'h0;
    endtask

    // Walks cycles T+1 .. T+CL+blen of a read, checking every beat's data and
    // valid, zero output outside the burst, and cmd_ready.
    task automatic run_read(input string name, input logic [31:0] exp, input int blen);
        for (int k = 1; k <= CL + blen; k++) begin
            logic       beat_on;
            logic [3:0] exp_dq;
            @(negedge clk);
            beat_on = (k >= CL) && (k < CL + blen);
            exp_dq  = beat_on ? exp[4 * (k - CL) +: 4] : 4'h0;
            check($sformatf("%s valid k=%0d", name, k), {7'd0, dqout_valid}, {7'd0, beat_on});
            check($sformatf("%s dqout k=%0d", name, k), {4'd0, dqout}, {4'd0, exp_dq});
            check($sformatf("%s ready k=%0d", name, k), {7'd0, cmd_ready},
                  {7'd0, (k == CL + blen)});
        end
    endtask

    initial begin
        int w;

        // Reset: held three cycles with a request present that must be ignored.
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst ready %0d", i), {7'd0, cmd_ready}, 8'd0);
            check($sformatf("rst valid %0d", i), {7'd0, dqout_valid}, 8'd0);
            check($sformatf("rst dqout %0d", i), {4'd0, dqout}, 8'd0);
            check($sformatf("rst wr_beat %0d", i), {7'd0, wr_beat}, 8'd0);
        end
        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("ready after release", {7'd0, cmd_ready}, 8'd1);
        check("no burst after release", {7'd0, dqout_valid | wr_beat}, 8'd0);

        // BL8 write of 1..8 to bg1 ba1 row1 col0, then read it back.
        start_cmd(1'b1, 1'b0, 2'd1, 2'd1, 4'd1, 5'd0, w);
        cmd_valid = 1'b0;
        run_write("wr_bl8", 32'h8765_4321, 8, 0);
        start_cmd(1'b0, 1'b0, 2'd1, 2'd1, 4'd1, 5'd0, w);
        cmd_valid = 1'b0;
        run_read("rd_bl8", 32'h8765_4321, 8);

        // Wrapped order from col5: 6,7,8,1,2,3,4,5.
        start_cmd(1'b0, 1'b0, 2'd1, 2'd1, 4'd1, 5'd5, w);
        cmd_valid = 1'b0;
        run_read("rd_wrap", 32'h5432_1876, 8);

        // BC4 write A,B,C,D from col6 lands on cols 6,7,4,5.
        start_cmd(1'b1, 1'b1, 2'd1, 2'd1, 4'd1, 5'd6, w);
        cmd_valid = 1'b0;
        run_write("wr_bc4", 32'h0000_DCBA, 4, 0);

        // Busy hold: first read col0 (1,2,3,4,C,D,A,B), second read col5
        // (D,A,B,1,2,3,4,C) queued behind it with cmd_valid never dropping.
        start_cmd(1'b0, 1'b0, 2'd1, 2'd1, 4'd1, 5'd0, w);
        cmd_col = 5'd5;
        run_read("busy1", 32'hBADC_4321, 8);
        start_cmd(1'b0, 1'b0, 2'd1, 2'd1, 4'd1, 5'd5, w);
        check("busy second accept wait", w[7:0], 8'd0);
        cmd_valid = 1'b0;
        run_read("busy2", 32'hC432_1BAD, 8);

        // Other bank: BC4 write 9,8,7,6 from col1 of bg2 ba0 row3 (cols 1,2,3,0),
        // BC4 read from col0 gives 6,9,8,7; the first bank is untouched.
        start_cmd(1'b1, 1'b1, 2'd2, 2'd0, 4'd3, 5'd1, w);
        cmd_valid = 1'b0;
        run_write("wr_bank2", 32'h0000_6789, 4, 0);
        start_cmd(1'b0, 1'b1, 2'd2, 2'd0, 4'd3, 5'd0, w);
        cmd_valid = 1'b0;
        run_read("rd_bank2", 32'h0000_7896, 4);
        start_cmd(1'b0, 1'b1, 2'd1, 2'd1, 4'd1, 5'd0, w);
        cmd_valid = 1'b0;
        run_read("rd_bank1_bc4", 32'h0000_4321, 4);

        // Known contents 8..F in cols 8..15 stand in for the unwritten state, so
        // the aborted write below can be shown to leave cols 10..15 alone.
        start_cmd(1'b1, 1'b0, 2'd1, 2'd1, 4'd1, 5'd8, w);
        cmd_valid = 1'b0;
        run_write("wr_fill", 32'hFEDC_BA98, 8, 0);

        // Reset during beat 2 of a BL8 write to col8: beats 0-1 persist.
        start_cmd(1'b1, 1'b0, 2'd1, 2'd1, 4'd1, 5'd8, w);
        cmd_valid = 1'b0;
        run_write("wr_abort", 32'h8765_4321, 8, CWL + 2);
        #1;
        check("abort wr_beat", {7'd0, wr_beat}, 8'd0);
        check("abort ready", {7'd0, cmd_ready}, 8'd0);
        check("abort valid", {7'd0, dqout_valid}, 8'd0);
        check("abort dqout", {4'd0, dqout}, 8'd0);
        dqin = 4'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready after abort", {7'd0, cmd_ready}, 8'd1);
        start_cmd(1'b0, 1'b0, 2'd1, 2'd1, 4'd1, 5'd8, w);
        cmd_valid = 1'b0;
        run_read("rd_abort", 32'hFEDC_BA21, 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_burst_chip.md
# ddr_burst_chip

Command-driven, multi-bank DRAM chip data model with burst sequencing. It accepts one RD/WR command at a time, addressed by bank group, bank, row and column. Each burst is a BL8 or BC4 burst, with sequential wrapped column ordering. Write data is sampled on `dqin` after CWL cycles; read data is driven on `dqout` after CL cycles. It sits under the DDR FSM as the storage/timing endpoint and supersedes the per-bank, per-beat row/column-driven chip model.

## Interface
- BGWIDTH, 2: bank-group index width; BANKGROUPS = 2**BGWIDTH.
- BAWIDTH, 2: bank-in-group index width; BANKSPERGROUP = 2**BAWIDTH.
- ADDRWIDTH, 4: row address width (sim-reduced); ROWS = 2**ADDRWIDTH.
- COLWIDTH, 5: column address width, must be ≥ 3; COLS = 2**COLWIDTH.
- DEVICE_WIDTH, 4: data beat width (x4/x8/x16).
- BL, 8: full burst length, fixed at 8; BC4 mode gives 4 beats.
- CL, 4: read latency in clk cycles, ≥ 1.
- CWL, 3: write latency in clk cycles, ≥ 1.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_bc4  in  1  1 = 4-beat burst chop, 0 = BL8.
- cmd_bg  in  BGWIDTH  bank group.
- cmd_ba  in  BAWIDTH  bank within group.
- cmd_row  in  ADDRWIDTH  row.
- cmd_col  in  COLWIDTH  starting column.
- dqin  in  DEVICE_WIDTH  write data beat.
- wr_beat  out  1  high in each cycle where `dqin` is sampled.
- dqout  out  DEVICE_WIDTH  read data beat; 0 when `dqout_valid` is low.
- dqout_valid  out  1  read beat valid.

## Operation
- Storage: BANKGROUPS×BANKSPERGROUP×ROWS×COLS words of DEVICE_WIDTH bits. Storage is not reset; unwritten locations read X.
- Handshake: a command is accepted on a rising edge where `cmd_valid && cmd_ready`. Command fields are captured at that edge.
- While `cmd_ready` is low, `cmd_valid` is ignored. The requester holds it; nothing is queued or dropped silently.
- FSM states:
  - IDLE: `cmd_ready` = 1. On accept → WAIT, with latency counter loaded to (cmd_we ? CWL : CL) − 1.
  - WAIT: counter decrements each cycle. At 0 → BURST, with beat counter = 0.
  - BURST: one beat per cycle. After the last beat (beat BLEN−1) → IDLE.
- BLEN = 4 if the captured bc4 = 1, else 8.
- Column for beat k:
  - BL8: {col[COLWIDTH-1:3], (col[2:0]+k) mod 8}.
  - BC4: {col[COLWIDTH-1:2], (col[1:0]+k) mod 4}.
  - Only the low 3 or 2 bits wrap; there is no carry into the upper bits.
- Write burst: in BURST, `wr_beat` = 1 and `dqin` is written to the beat's column at the end of the cycle.
- Read burst: in BURST, `dqout_valid` = 1 and `dqout` = stored word for the beat's column. A write and read at the same address cannot overlap, because only one burst is outstanding.
- Bank/row/column are captured per command. There is no ACT/PRE modelling; row-open policy belongs to the DDR FSM.

## Timing
- Reset values: `cmd_ready` = 0, `dqout_valid` = 0, `dqout` = 0, `wr_beat` = 0, FSM = IDLE.
- `cmd_ready` rises on the first clk edge after `reset_n` deasserts.
- Let the accept edge end cycle T:
  - Reads: beats are in cycles T+CL … T+CL+BLEN−1.
  - Writes: beats are sampled in cycles T+CWL … T+CWL+BLEN−1.
- `cmd_ready` is low from cycle T+1 through the last beat cycle. It is high again in the cycle after the last beat. The minimum command-to-command spacing is therefore L+BLEN cycles, where L = CL or CWL.
- All outputs are registered, except that `dqout` is the registered read of the beat address, valid in the same cycle as `dqout_valid`.
- Reset mid-burst: all outputs go to reset values immediately (asynchronously). Remaining write beats are not performed; beats already written persist.
- `cmd_valid` asserted during reset has no effect.

## Test plan
- Reset then idle: hold reset_n=0 for 3 cycles, release → `cmd_ready` = 0 during reset, 1 one edge after release; `dqout_valid` = 0, `dqout` = 0.
- BL8 write/read: write bg1 ba1 row1 col0 with beats 0x1..0x8 → `wr_beat` high in cycles T+3..T+10. Read back the same address → `dqout` = 1..8 in cycles T'+4..T'+11, with `dqout_valid` high exactly 8 cycles.
- Wrap order: after the above, read col5 (BL8) → `dqout` = 6,7,8,1,2,3,4,5.
- BC4: write col 6 bc4 with 0xA,0xB,0xC,0xD → stored at cols 6,7,4,5. A BL8 read from col0 → `dqout` = 1,2,3,4,0xC,0xD,0xA,0xB.
- Busy hold: assert `cmd_valid` continuously with 2 queued reads → the second is accepted only in the cycle after the first's last beat. There is no beat overlap and `dqout_valid` has no gap glitches.
- Reset mid-write: assert reset_n=0 after beat 2 of a BL8 write to fresh col 8 → beats 0–1 stored, cols 10–15 unchanged (still X). Outputs go to 0 immediately; the next command is accepted normally after release.
